// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants and the fetch-stage state encoding.
package fetch_stage_pkg;

    localparam int unsigned DEF_PC_W = 10;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned CNT_W    = 16;

    localparam logic [INSTR_W-1:0] DEF_NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush inserts a NOP bubble, hold keeps the current contents.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int unsigned        PC_W      = DEF_PC_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic               valid_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [PC_W-1:0]    pc_plus1_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o,
    output logic [PC_W-1:0]    pc_plus1_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_plus1_q;

    // Flush keeps the pc fields so downstream still sees the last real address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus1_q <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end else if (load_i) begin
            valid_q    <= valid_i;
            instr_q    <= instr_i;
            pc_q       <= pc_i;
            pc_plus1_q <= pc_plus1_i;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus1_o = pc_plus1_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a synchronous instruction memory and fills IF/ID,
// honouring decode stalls and downstream redirects.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned        PC_W      = DEF_PC_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_q,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic [PC_W-1:0]    id_pc_plus1,
    output logic [CNT_W-1:0]   bubble_cnt
);

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic             rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [PC_W-1:0]  pc_plus1;
    logic             if_load;
    logic             if_flush;

    // Single incrementer shared by sequential fetch and the IF/ID link value.
    assign pc_plus1 = fetch_pc_q + PC_W'(1);

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        rd_valid_d   = rd_valid_q;
        bubble_cnt_d = bubble_cnt_q;
        imem_addr    = '0;
        if_load      = 1'b0;
        if_flush     = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d    = ST_RUN;
                fetch_pc_d = '0;
                rd_valid_d = 1'b1;
            end
            ST_RUN: begin
                if (redirect) begin
                    imem_addr  = redirect_pc;
                    fetch_pc_d = redirect_pc;
                    rd_valid_d = 1'b1;
                    if_flush   = 1'b1;
                end else if (stall) begin
                    imem_addr = fetch_pc_q;
                end else begin
                    imem_addr  = pc_plus1;
                    fetch_pc_d = pc_plus1;
                    if_load    = 1'b1;
                end
                if ((stall || redirect) && (bubble_cnt_q != '1)) begin
                    bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_BOOT;
            fetch_pc_q   <= '0;
            rd_valid_q   <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            rd_valid_q   <= rd_valid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    if_id_reg #(
        .PC_W      (PC_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load_i     (if_load),
        .flush_i    (if_flush),
        .valid_i    (rd_valid_q),
        .instr_i    (imem_q),
        .pc_i       (fetch_pc_q),
        .pc_plus1_i (pc_plus1),
        .valid_o    (id_valid),
        .instr_o    (id_instr),
        .pc_o       (id_pc),
        .pc_plus1_o (id_pc_plus1)
    );

    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table, directed corner cases and a
// random run against an instruction-stream reference model.
module tb_fetch_stage;

    localparam int unsigned PW  = 10;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic          clk;
    logic          rst;
    logic          stall;
    logic          redirect;
    logic [PW-1:0] redirect_pc;
    logic [PW-1:0] imem_addr;
    logic [31:0]   imem_q;
    logic          id_valid;
    logic [31:0]   id_instr;
    logic [PW-1:0] id_pc;
    logic [PW-1:0] id_pc_plus1;
    logic [15:0]   bubble_cnt;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_q      (imem_q),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus1 (id_pc_plus1),
        .bubble_cnt  (bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous instruction memory with IM[i] = i + 100.
    always @(posedge clk) imem_q <= 32'(imem_addr) + 32'd100;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the stream of instructions the decoder should see.
    bit            m_boot;
    logic [PW-1:0] m_next;
    logic          e_valid;
    logic [31:0]   e_instr;
    logic [PW-1:0] e_pc;
    logic [PW-1:0] e_plus1;
    logic [PW-1:0] e_addr;
    logic [PW-1:0] addr_pre;
    int            e_bcnt;

    typedef struct {
        logic          s;
        logic          r;
        logic [PW-1:0] rp;
        logic [PW-1:0] addr;
        logic          v;
        logic [PW-1:0] pc;
        logic [PW-1:0] p1;
        int            bc;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_boot  = 1'b1;
        m_next  = '0;
        e_valid = 1'b0;
        e_instr = NOP;
        e_pc    = '0;
        e_plus1 = '0;
        e_bcnt  = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".imem_addr"}, 32'(addr_pre), 32'(e_addr));
        chk({tag, ".id_valid"}, 32'(id_valid), 32'(e_valid));
        chk({tag, ".id_instr"}, id_instr, e_instr);
        chk({tag, ".id_pc"}, 32'(id_pc), 32'(e_pc));
        chk({tag, ".id_pc_plus1"}, 32'(id_pc_plus1), 32'(e_plus1));
        chk({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'(e_bcnt));
    endtask

    // One clock: drive inputs, sample the address, step the model across the edge.
    task automatic apply(input logic s, input logic r, input logic [PW-1:0] rp);
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        if (m_boot)  e_addr = '0;
        else if (r)  e_addr = rp;
        else if (s)  e_addr = m_next;
        else         e_addr = m_next + PW'(1);
        #1;
        addr_pre = imem_addr;
        @(posedge clk);
        if (m_boot) begin
            m_boot = 1'b0;
            m_next = '0;
        end else begin
            if (s || r) e_bcnt = (e_bcnt < 65535) ? e_bcnt + 1 : 65535;
            if (r) begin
                e_valid = 1'b0;
                e_instr = NOP;
                m_next  = rp;
            end else if (!s) begin
                e_valid = 1'b1;
                e_pc    = m_next;
                e_plus1 = m_next + PW'(1);
                e_instr = 32'(m_next) + 32'd100;
                m_next  = m_next + PW'(1);
            end
        end
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst      = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        #1;
        model_reset();
        e_addr   = '0;
        addr_pre = imem_addr;
        check_model(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        model_reset();

        tbl[0]  = '{1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 10'h000, 10'h000, 0};
        tbl[1]  = '{1'b0, 1'b0, 10'h000, 10'h001, 1'b1, 10'h000, 10'h001, 0};
        tbl[2]  = '{1'b0, 1'b0, 10'h000, 10'h002, 1'b1, 10'h001, 10'h002, 0};
        tbl[3]  = '{1'b1, 1'b0, 10'h000, 10'h002, 1'b1, 10'h001, 10'h002, 1};
        tbl[4]  = '{1'b0, 1'b1, 10'h200, 10'h200, 1'b0, 10'h001, 10'h002, 2};
        tbl[5]  = '{1'b0, 1'b0, 10'h000, 10'h201, 1'b1, 10'h200, 10'h201, 2};
        tbl[6]  = '{1'b1, 1'b1, 10'h3FE, 10'h3FE, 1'b0, 10'h200, 10'h201, 3};
        tbl[7]  = '{1'b0, 1'b0, 10'h000, 10'h3FF, 1'b1, 10'h3FE, 10'h3FF, 3};
        tbl[8]  = '{1'b0, 1'b0, 10'h000, 10'h000, 1'b1, 10'h3FF, 10'h000, 3};
        tbl[9]  = '{1'b0, 1'b0, 10'h000, 10'h001, 1'b1, 10'h000, 10'h001, 3};
        tbl[10] = '{1'b1, 1'b0, 10'h000, 10'h001, 1'b1, 10'h000, 10'h001, 4};
        tbl[11] = '{1'b0, 1'b0, 10'h000, 10'h002, 1'b1, 10'h001, 10'h002, 4};

        #12;
        do_reset("reset0");

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].s, tbl[i].r, tbl[i].rp);
            chk($sformatf("tbl%0d.imem_addr", i), 32'(addr_pre), 32'(tbl[i].addr));
            chk($sformatf("tbl%0d.id_valid", i), 32'(id_valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d.id_pc", i), 32'(id_pc), 32'(tbl[i].pc));
            chk($sformatf("tbl%0d.id_pc_plus1", i), 32'(id_pc_plus1), 32'(tbl[i].p1));
            chk($sformatf("tbl%0d.id_instr", i), id_instr,
                tbl[i].v ? 32'(tbl[i].pc) + 32'd100 : NOP);
            chk($sformatf("tbl%0d.bubble_cnt", i), 32'(bubble_cnt), 32'(tbl[i].bc));
        end

        // Three-cycle stall while id_pc = 5.
        do_reset("reset1");
        repeat (7) apply(1'b0, 1'b0, '0);
        chk("stall.pre_pc", 32'(id_pc), 32'd5);
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 1'b0, '0);
            check_model("stall");
            chk("stall.hold_pc", 32'(id_pc), 32'd5);
        end
        apply(1'b0, 1'b0, '0);
        chk("stall.next_pc", 32'(id_pc), 32'd6);
        chk("stall.bcnt", 32'(bubble_cnt), 32'd3);

        // Redirect from fetch_pc 0x010 to 0x200, alone and together with a stall.
        for (int mode = 0; mode < 2; mode++) begin
            do_reset("reset2");
            repeat (17) apply(1'b0, 1'b0, '0);
            chk("redir.pre_pc", 32'(id_pc), 32'h00F);
            apply(mode[0], 1'b1, 10'h200);
            chk("redir.addr", 32'(addr_pre), 32'h200);
            chk("redir.bubble_valid", 32'(id_valid), 32'd0);
            chk("redir.bubble_instr", id_instr, NOP);
            apply(1'b0, 1'b0, '0);
            chk("redir.target_pc", 32'(id_pc), 32'h200);
            chk("redir.target_valid", 32'(id_valid), 32'd1);
            chk("redir.target_instr", id_instr, 32'h200 + 32'd100);
        end

        // Asynchronous reset between edges during a stall.
        do_reset("reset3");
        repeat (5) apply(1'b0, 1'b0, '0);
        stall = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        e_addr   = '0;
        addr_pre = imem_addr;
        check_model("async_rst");
        @(negedge clk);
        rst   = 1'b1;
        stall = 1'b0;
        apply(1'b0, 1'b0, '0);
        apply(1'b0, 1'b0, '0);
        check_model("restart");
        chk("restart.pc", 32'(id_pc), 32'd0);
        chk("restart.instr", id_instr, 32'd100);

        // Randomised traffic against the model.
        do_reset("reset4");
        for (int n = 0; n < 3000; n++) begin
            apply($urandom_range(3, 0) == 0, $urandom_range(9, 0) == 0,
                  PW'($urandom));
            check_model("rnd");
        end

        // bubble_cnt saturation.
        do_reset("reset5");
        apply(1'b0, 1'b0, '0);
        stall = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat.bubble_cnt", 32'(bubble_cnt), 32'h0000_FFFF);
        chk("sat.id_valid", 32'(id_valid), 32'd0);
        stall = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_W, default 10, instruction-word address width (1 K-word instruction memory).
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, word driven on id_instr during bubbles.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  decode-stage hold request (load-use); freezes fetch PC and IF/ID.
REQ-006 redirect  input  1  taken branch/jump/jal/jr resolved downstream.
REQ-007 redirect_pc  input  PC_W  target word address for redirect.
REQ-008 imem_addr  output  PC_W  address to synchronous instruction memory; data returns on imem_q one clock later.
REQ-009 imem_q  input  32  instruction memory read data.
REQ-010 id_valid  output  1  IF/ID holds a real instruction.
REQ-011 id_instr  output  32  registered instruction to decode.
REQ-012 id_pc  output  PC_W  address of id_instr.
REQ-013 id_pc_plus1  output  PC_W  id_pc+1, for branch adder and jal link.
REQ-014 bubble_cnt  output  16  saturating count of stall/redirect cycles.

Function
REQ-015 Two states: BOOT and RUN; BOOT lasts exactly one clock after reset release, then RUN permanently.
REQ-016 Internal fetch_pc = address whose data is on imem_q this cycle; rd_valid flags imem_q as meaningful.
REQ-017 imem_addr combinational: BOOT -> 0; RUN with redirect -> redirect_pc; RUN with stall only -> fetch_pc; otherwise fetch_pc+1.
REQ-018 BOOT edge: fetch_pc <= 0, rd_valid <= 1, IF/ID unchanged (invalid); stall and redirect ignored in BOOT.
REQ-019 RUN normal edge (no stall, no redirect): IF/ID <= {rd_valid, imem_q, fetch_pc, fetch_pc+1}; fetch_pc <= fetch_pc+1.
REQ-020 RUN stall edge (stall=1, redirect=0): fetch_pc, rd_valid and all IF/ID outputs hold.
REQ-021 RUN redirect edge: fetch_pc <= redirect_pc, rd_valid <= 1, id_valid <= 0, id_instr <= NOP_INSTR, id_pc/id_pc_plus1 hold; wrong-path imem_q discarded.
REQ-022 Redirect and stall simultaneous: redirect wins (flush overrides hold).
REQ-023 Latency: address A on imem_addr in cycle n -> instruction visible on id_* after the edge ending cycle n+1; redirect costs exactly one bubble.
REQ-024 PC arithmetic modulo 2^PC_W: 3FF+1 wraps to 000, for fetch_pc and id_pc_plus1.
REQ-025 bubble_cnt increments on every RUN edge with stall or redirect asserted; saturates at 16'hFFFF.

Reset
REQ-026 rst=0 asynchronously forces: state BOOT, fetch_pc 0, rd_valid 0, id_valid 0, id_instr NOP_INSTR, id_pc 0, id_pc_plus1 0, bubble_cnt 0; imem_addr reads 0.
REQ-027 Reset mid-operation discards any in-flight fetch, stall or redirect; first instruction after release is address 0.

Structure
REQ-028 PC_W, INSTR_W (32), NOP_INSTR and the BOOT/RUN state encoding live in the shared cpu package.
REQ-029 One sub-module: if_id_reg (IF/ID pipeline register with hold and flush); PC+1 uses the existing adder.

Verification
REQ-030 Reset release, no stall/redirect, IM[i]=i+100 -> id_pc 0,1,2,... on consecutive edges from the 2nd edge after release, id_instr matches, id_valid 1.
REQ-031 Stall held 3 cycles at id_pc=5 -> id_* frozen at 5 for 3 cycles, then 6; bubble_cnt +3.
REQ-032 Redirect to 0x200 while fetch_pc=0x010 -> one id_valid=0 cycle with NOP_INSTR, next id_pc=0x200.
REQ-033 Redirect and stall same cycle -> identical to REQ-032 response.
REQ-034 Run to fetch_pc 0x3FF -> id_pc 0x3FF with id_pc_plus1 0x000, next id_pc 0x000.
REQ-035 rst asserted between edges during a stall -> outputs at reset values immediately; after release fetch restarts at 0; 70000 stall cycles -> bubble_cnt 16'hFFFF.
